// File: rtl/countdown_timer.sv
// Loadable down-counter with expiry pulse and optional auto-reload.
// IDLE/RUN/DONE controller; done is a registered one-cycle pulse.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             count,
  input  logic             reload_en,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic             r_done;
  logic             w_expire;

  assign w_expire = (r_state == RUN) && (r_q == WIDTH'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else if (clear) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else if (load) begin
      r_q      <= d;
      r_reload <= d;
      r_done   <= 1'b0;
      r_state  <= (d != '0) ? RUN : IDLE;
    end else if (count && r_state == RUN) begin
      if (w_expire) begin
        r_done <= 1'b1;
        // Auto-reload skips the zero value entirely; one-shot parks in DONE.
        if (reload_en) begin
          r_q <= r_reload;
        end else begin
          r_q     <= '0;
          r_state <= DONE;
        end
      end else begin
        r_q    <= r_q - WIDTH'(1);
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign q    = r_q;
  assign zero = (r_q == '0);
  assign busy = (r_state == RUN);
  assign done = r_done;

endmodule
